// File: rtl/pipe_reg_elastic_pkg.sv
// Shared types for the elastic pipeline register: payload layout and bubble control.
// Module widths must not exceed the *_MAX bounds below.
package pipe_reg_elastic_pkg;
  localparam int DATA_W_MAX = 32;
  localparam int CTRL_W_MAX = 4;
  localparam int IDX_W_MAX  = 5;

  typedef struct packed {
    logic [DATA_W_MAX-1:0] address;
    logic [DATA_W_MAX-1:0] next_pc;
    logic                  alu_zero;
    logic [DATA_W_MAX-1:0] data;
    logic [CTRL_W_MAX-1:0] control;
    logic [IDX_W_MAX-1:0]  rgD_index;
  } payload_t;

  localparam logic [CTRL_W_MAX-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_reg_elastic_entry.sv
// One payload slot: loads on enable, clears synchronously on reset.
module pipe_entry_reg
  import pipe_reg_elastic_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  payload_t d,
  output payload_t q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: one-cycle latency, optional skid slot for full
// throughput without a combinational out_ready -> in_ready path.
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int DATA_W = DATA_W_MAX,
  parameter int CTRL_W = CTRL_W_MAX,
  parameter int IDX_W  = IDX_W_MAX,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] address_in,
  input  logic [DATA_W-1:0] next_pc_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              alu_zero_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [IDX_W-1:0]  rgD_index_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] address_out,
  output logic [DATA_W-1:0] next_pc_out,
  output logic [DATA_W-1:0] data_out,
  output logic              alu_zero_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [IDX_W-1:0]  rgD_index_out,
  output logic [1:0]        occupancy
);
  payload_t in_pl, main_d, main_q, skid_q;
  logic     main_valid, skid_valid;
  logic     push, pop, skid_pop, load_main;

  always_comb begin
    in_pl           = '0;
    in_pl.address   = DATA_W_MAX'(address_in);
    in_pl.next_pc   = DATA_W_MAX'(next_pc_in);
    in_pl.data      = DATA_W_MAX'(data_in);
    in_pl.alu_zero  = alu_zero_in;
    in_pl.control   = CTRL_W_MAX'(control_in);
    in_pl.rgD_index = IDX_W_MAX'(rgD_index_in);
  end

  assign out_valid = main_valid & write;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // in_ready is low whenever skid is full, so skid_pop never coincides with push
  assign skid_pop  = pop & skid_valid;
  assign load_main = !flush & (skid_pop | (push & (!main_valid | pop)));
  assign main_d    = skid_pop ? skid_q : in_pl;

  always_ff @(posedge clk) begin
    if (reset)          main_valid <= 1'b0;
    else if (flush)     main_valid <= 1'b0;
    else if (load_main) main_valid <= 1'b1;
    else if (pop)       main_valid <= 1'b0;
  end

  pipe_entry_reg u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID) begin : g_skid
      logic load_skid;
      assign load_skid = !flush & push & main_valid & !pop;
      assign in_ready  = !skid_valid & write & !flush;

      always_ff @(posedge clk) begin
        if (reset)          skid_valid <= 1'b0;
        else if (flush)     skid_valid <= 1'b0;
        else if (load_skid) skid_valid <= 1'b1;
        else if (skid_pop)  skid_valid <= 1'b0;
      end

      pipe_entry_reg u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid),
        .d     (in_pl),
        .q     (skid_q)
      );
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
      assign in_ready   = write & !flush & (!out_valid | out_ready);
    end
  endgenerate

  assign address_out   = main_q.address[DATA_W-1:0];
  assign next_pc_out   = main_q.next_pc[DATA_W-1:0];
  assign data_out      = main_q.data[DATA_W-1:0];
  assign alu_zero_out  = main_q.alu_zero;
  assign control_out   = main_valid ? main_q.control[CTRL_W-1:0] : CTRL_BUBBLE[CTRL_W-1:0];
  assign rgD_index_out = main_q.rgD_index[IDX_W-1:0];
  assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each data-carrying field (address, next_pc, data).
REQ-002 SHALL have parameter CTRL_W, default 4, width of the control field.
REQ-003 SHALL have parameter IDX_W, default 5, width of the destination-register index field.
REQ-004 SHALL have parameter SKID, default 1: 1 = two-entry skid stage (full throughput); 0 = single-entry stage.
REQ-005 SHALL have ports, clock and reset first:
  clk  in  1  single clock, all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  write  in  1  stage enable; 0 = global stall
  flush  in  1  discard all held entries (bubble insert)
  in_valid  in  1  upstream entry present
  in_ready  out  1  stage accepts entry this cycle
  address_in, next_pc_in, data_in  in  DATA_W each  payload fields
  alu_zero_in  in  1  ALU zero flag
  control_in  in  CTRL_W  control bits
  rgD_index_in  in  IDX_W  destination register index
  out_valid  out  1  downstream entry present
  out_ready  in  1  downstream accepts entry
  address_out, next_pc_out, data_out, alu_zero_out, control_out, rgD_index_out  out  widths as inputs  held payload
  occupancy  out  2  entries held (0..2)

Function
REQ-006 SHALL carry every bit of every field at full width; no field truncated (all DATA_W, CTRL_W, IDX_W bits registered).
REQ-007 SHALL push when in_valid & in_ready; pop when out_valid & out_ready; both qualified by write=1.
REQ-008 SHALL have latency exactly one cycle: entry pushed at edge N is on outputs with out_valid=1 after edge N.
REQ-009 SKID=1: in_ready SHALL equal !skid_valid & write & !flush (skid_valid registered, no combinational path out_ready->in_ready).
REQ-010 SKID=1: push with main empty, or push with simultaneous pop and skid empty, SHALL load main; push with main full and no pop SHALL load skid.
REQ-011 SKID=1: pop with skid full SHALL move skid into main in the same edge; in that cycle in_ready is 0, so no third entry exists.
REQ-012 SKID=0: in_ready SHALL equal write & !flush & (!out_valid | out_ready); occupancy never exceeds 1.
REQ-013 Order SHALL be preserved: entries leave in acceptance order.
REQ-014 out_valid SHALL equal main_valid & write; write=0 SHALL freeze all state and force in_ready=0, out_valid=0.
REQ-015 When main empty, control_out SHALL be all zero (bubble); other outputs hold last value.
REQ-016 flush=1 SHALL clear main_valid and skid_valid at the next edge irrespective of write, in_valid, out_ready; input that cycle is discarded; flush wins over push and pop.
REQ-017 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-018 reset=1 at an edge SHALL clear main_valid, skid_valid, all payload registers and control to zero; reset wins over flush, write and handshakes.
REQ-019 After reset: out_valid=0, in_ready=write (if SKID=1) / write (if SKID=0), occupancy=0, all outputs 0.
REQ-020 Reset asserted mid-transfer SHALL drop all held entries; nothing is emitted afterwards.

Structure
REQ-021 Shared package SHALL hold the payload struct type (address, next_pc, alu_zero, data, control, rgD_index) and the bubble-control constant (all zero).
REQ-022 One sub-module, pipe_entry_reg (payload register with load enable and sync clear), SHALL be instantiated once for main and once for skid (omitted when SKID=0).

Verification
REQ-023 Reset then idle: reset=1 two cycles -> out_valid=0, control_out=0, occupancy=0, in_ready=1 with write=1.
REQ-024 Streaming: in_valid=1, out_ready=1, data_in=1,2,3,4 on consecutive cycles -> data_out=1,2,3,4 one cycle later each, no bubbles.
REQ-025 Backpressure: out_ready=0, push A=0xAAAA_0001, B=0xBBBB_0002 -> occupancy=2, in_ready=0; release out_ready -> A then B out, occupancy 2->1->0.
REQ-026 Flush vs push: occupancy=1, flush=1 with in_valid=1 (C=0xC) -> next cycle occupancy=0, out_valid=0, control_out=0, C never appears.
REQ-027 Stall: write=0 for 3 cycles with occupancy=2 -> all outputs and occupancy unchanged, in_ready=0, out_valid=0; write=1 -> draining resumes in order.
REQ-028 Width: data_in=0xFFFF_FFFF, control_in=0xF, rgD_index_in=31, alu_zero_in=1 -> identical values at outputs (checks MSBs registered); repeat with SKID=0.
